store_drain_buffer: RTL and testbench
=====================================

// Module: store_drain_buffer
// PURPOSE
//  Store-side counterpart of the load return path. Holds ROB-committed stores in
//  a FIFO, aligns them into word lanes with byte mask, and drains them to the
//  DTCM write port on a valid/ready handshake. Supplies per-byte forward data
//  and hit mask to the load pipe for bytes not yet written to memory.
// PARAMETERS
//  DEPTH   8   entries; power of two, >=2
//  XLEN    32  data width; only 32 supported (4 byte lanes)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset; asynchronous, active-low
//  commit_valid     in   1   committed store offered
//  commit_ready     out  1   entry free (= !full)
//  commit_addr      in   32  byte address of store
//  commit_data      in   32  unaligned rs2 value
//  commit_size      in   2   mem_op_size_t (BYTE/HALF_WORD/WORD/DUMMY0)
//  dmem_req_valid   out  1   head entry write request
//  dmem_req_ready   in   1   DTCM accepts write
//  dmem_req_addr    out  32  word address {addr[31:2],2'b00}
//  dmem_req_wdata   out  32  lane-aligned write data
//  dmem_req_wmask   out  4   byte write enables
//  fwd_addr         in   32  load address probed (bits [1:0] ignored)
//  fwd_data         out  32  forwarded bytes, lane-aligned
//  fwd_hit_mask     out  4   bytes supplied by buffer
//  fwd_valid        out  1   |fwd_hit_mask
//  drain_empty      out  1   no entries pending (fence/drain condition)
// BEHAVIOUR
//  - Reset (rst low, async): head/tail/count cleared, all entry valids 0.
//    Outputs during/after reset: commit_ready=1, dmem_req_valid=0, fwd_valid=0,
//    fwd_hit_mask=0, drain_empty=1. Entry data/addr storage not reset.
//    Mid-operation reset discards pending stores; dmem_req_valid drops at once.
//  - Enqueue on commit_valid&&commit_ready. Alignment, a=addr[1:0]:
//    BYTE: wdata={4{d[7:0]}},  wmask=4'b0001<<a
//    HALF: wdata={2{d[15:0]}}, wmask=(4'b0011<<a)[3:0]
//    WORD: wdata=d,            wmask=4'b1111 (a ignored)
//    DUMMY0: handshake completes, nothing enqueued.
//    Misaligned HALF (a=3) truncates mask to 4'b1000; misalignment trapped upstream.
//  - Drain: dmem_req_valid=!empty; addr/wdata/wmask come from head entry and
//    stay stable until dmem_req_ready. Dequeue on valid&&ready, 1 entry/cycle.
//  - Latency: store enqueued in cycle N is presented on dmem_req in N+1 at earliest.
//  - Full: commit_ready=0; no enqueue-on-dequeue pass-through (ready is
//    registered-state only). Simultaneous enq+deq when not full: count unchanged.
//  - Pointers DEPTH-wrap with extra MSB; full = ptrs equal except MSB.
//  - Forwarding (combinational): compare fwd_addr[31:2] to every valid entry;
//    per byte lane, youngest matching entry with that mask bit wins.
//    Lanes with no hit: fwd_data byte=0, hit bit=0.
//  - Entry being dequeued this cycle still forwards this cycle; entry enqueued
//    this cycle forwards from next cycle.
//  - Stores are architectural: no flush/recovery input; never drops entries.
// STRUCTURE
//  - Falco_pkg: store_drain_entry_t {word_addr[29:0], wdata, wmask},
//    STORE_DRAIN_DEPTH constant; reuses mem_op_size_t, byte_mask_t, xlen_data_t.
//  - Sub-module store_align: combinational (size, a, data) -> (wdata, wmask).
//  - Forward search: age-ordered priority per lane relative to head pointer.
// TESTING
//  1. Reset: hold rst low with commit_valid=1 -> no enqueue, drain_empty=1,
//     dmem_req_valid=0, commit_ready=1.
//  2. SB addr 0x1003 data 0xAB, SH 0x1002 data 0x1234, SW 0x2000 0xDEADBEEF ->
//     requests (0x1000,0xABABABAB,1000),(0x1000,0x12341234,1100),
//     (0x2000,0xDEADBEEF,1111) in order.
//  3. dmem_req_ready=0, push 8 stores -> commit_ready=0 after 8th; 9th held;
//     head outputs stable; release ready -> 8 writes in FIFO order, then empty.
//  4. SW 0x3000 0x11223344 then SB 0x3001 0xAA, probe 0x3000 -> fwd_data
//     0x1122AA44, hit_mask 1111; probe 0x3004 -> fwd_valid=0.
//  5. Full buffer, ready=1 and commit_valid=1 same cycle -> dequeue only;
//     next cycle enqueue accepted, count back to 8.
//  6. Async reset asserted mid-drain with 5 entries -> dmem_req_valid=0
//     immediately, drain_empty=1; post-reset store drains correctly.

Source files
------------

// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the store drain buffer: access size encoding, byte masks
// and the queued entry layout.
package store_drain_buffer_pkg;

   typedef enum logic [1:0] {
      BYTE      = 2'd0,
      HALF_WORD = 2'd1,
      WORD      = 2'd2,
      DUMMY0    = 2'd3
   } mem_op_size_t;

   typedef logic [3:0]  byte_mask_t;
   typedef logic [31:0] xlen_data_t;

   typedef struct packed {
      logic [29:0] word_addr;
      xlen_data_t  wdata;
      byte_mask_t  wmask;
   } store_drain_entry_t;

   localparam int STORE_DRAIN_DEPTH = 8;

endpackage

// File: rtl/store_drain_buffer_align.sv
// Replicates store data across byte lanes and builds the byte write mask
// from the access size and the low address bits.
module store_drain_buffer_align
   import store_drain_buffer_pkg::*;
(
   input  mem_op_size_t size,
   input  logic [1:0]   a,
   input  xlen_data_t   data,
   output xlen_data_t   wdata,
   output byte_mask_t   wmask
);

   always_comb begin
      wdata = data;
      wmask = 4'b0000;
      case (size)
         BYTE: begin
            wdata = {4{data[7:0]}};
            wmask = 4'b0001 << a;
         end
         HALF_WORD: begin
            // A halfword at offset 3 falls off the top lane; upstream traps it.
            wdata = {2{data[15:0]}};
            wmask = 4'b0011 << a;
         end
         WORD: begin
            wdata = data;
            wmask = 4'b1111;
         end
         default: begin
            wdata = data;
            wmask = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/store_drain_buffer.sv
// FIFO of committed stores drained to the DTCM write port, with per-byte
// store-to-load forwarding of entries still waiting to be written.
module store_drain_buffer
   import store_drain_buffer_pkg::*;
#(
   parameter int DEPTH = STORE_DRAIN_DEPTH,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   output logic            commit_ready,
   input  logic [31:0]     commit_addr,
   input  logic [XLEN-1:0] commit_data,
   input  mem_op_size_t    commit_size,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [31:0]     dmem_req_addr,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [3:0]      dmem_req_wmask,
   input  logic [31:0]     fwd_addr,
   output logic [XLEN-1:0] fwd_data,
   output logic [3:0]      fwd_hit_mask,
   output logic            fwd_valid,
   output logic            drain_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        head_reg, tail_reg;
   logic [DEPTH-1:0]   valid_reg;
   store_drain_entry_t entry_mem [DEPTH];

   logic [AW-1:0]      head_idx, tail_idx;
   logic               full, empty, enq, deq;
   xlen_data_t         al_wdata;
   byte_mask_t         al_wmask;
   store_drain_entry_t head_entry;
   logic [1:0]         unused_fwd_lsb;

   assign head_idx = head_reg[AW-1:0];
   assign tail_idx = tail_reg[AW-1:0];
   assign empty    = (head_reg == tail_reg);
   assign full     = (head_reg[AW] != tail_reg[AW]) && (head_idx == tail_idx);

   assign commit_ready = !full;
   // DUMMY0 completes the handshake but never occupies an entry.
   assign enq = commit_valid && !full && (commit_size != DUMMY0);
   assign deq = !empty && dmem_req_ready;

   store_drain_buffer_align u_align (
      .size  (commit_size),
      .a     (commit_addr[1:0]),
      .data  (commit_data),
      .wdata (al_wdata),
      .wmask (al_wmask)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         valid_reg <= '0;
      end else begin
         if (enq) begin
            valid_reg[tail_idx] <= 1'b1;
            tail_reg            <= tail_reg + 1'b1;
         end
         if (deq) begin
            valid_reg[head_idx] <= 1'b0;
            head_reg            <= head_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq)
         entry_mem[tail_idx] <= '{word_addr: commit_addr[31:2], wdata: al_wdata, wmask: al_wmask};
   end

   assign head_entry     = entry_mem[head_idx];
   assign dmem_req_valid = !empty;
   assign dmem_req_addr  = {head_entry.word_addr, 2'b00};
   assign dmem_req_wdata = head_entry.wdata;
   assign dmem_req_wmask = head_entry.wmask;
   assign drain_empty    = empty;

   // Walk oldest to youngest from head so the youngest matching byte is kept last.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0]    lane_byte;
      logic          lane_hit;
      logic [AW-1:0] idx;

      always_comb begin
         lane_byte = '0;
         lane_hit  = 1'b0;
         idx       = '0;
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + AW'(i);
            if (valid_reg[idx] && (entry_mem[idx].word_addr == fwd_addr[31:2])
                && entry_mem[idx].wmask[gi]) begin
               lane_hit  = 1'b1;
               lane_byte = entry_mem[idx].wdata[8*gi +: 8];
            end
         end
      end

      assign fwd_data[8*gi +: 8] = lane_byte;
      assign fwd_hit_mask[gi]    = lane_hit;
   end

   assign fwd_valid      = |fwd_hit_mask;
   assign unused_fwd_lsb = fwd_addr[1:0];

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: table vectors, corner sequences and random
// traffic compared against a queue-based reference model.
module tb_store_drain_buffer;
   import store_drain_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         commit_valid = 1'b0;
   logic         commit_ready;
   logic [31:0]  commit_addr = '0;
   logic [31:0]  commit_data = '0;
   mem_op_size_t commit_size = WORD;
   logic         dmem_req_valid;
   logic         dmem_req_ready = 1'b0;
   logic [31:0]  dmem_req_addr;
   logic [31:0]  dmem_req_wdata;
   logic [3:0]   dmem_req_wmask;
   logic [31:0]  fwd_addr = '0;
   logic [31:0]  fwd_data;
   logic [3:0]   fwd_hit_mask;
   logic         fwd_valid;
   logic         drain_empty;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_drain_buffer dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_addr(commit_addr), .commit_data(commit_data), .commit_size(commit_size),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
      .dmem_req_wmask(dmem_req_wmask),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_hit_mask(fwd_hit_mask),
      .fwd_valid(fwd_valid), .drain_empty(drain_empty)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  mask;
   } ent_t;

   ent_t q[$];

   function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] d, input int sz);
      ent_t e;
      int   off;
      off     = int'(a % 4);
      e.waddr = a[31:2];
      e.data  = d;
      e.mask  = 4'hF;
      if (sz == 0) begin
         e.data = 32'(d % 256) * 32'h0101_0101;
         e.mask = 4'(1 << off);
      end else if (sz == 1) begin
         e.data = 32'(d % 65536) * 32'h0001_0001;
         e.mask = 4'((3 << off) % 16);
      end
      return e;
   endfunction

   // Youngest-first search per lane; first hit wins.
   task automatic model_fwd(input logic [31:0] a, output logic [31:0] d, output logic [3:0] m);
      logic [31:0] src;
      d = '0;
      m = '0;
      for (int l = 0; l < 4; l++) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].waddr == a[31:2] && q[i].mask[l]) begin
               m[l] = 1'b1;
               src  = q[i].data;
               d    = d | (src & (32'hFF << (8 * l)));
               break;
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive at negedge, compare against model state, update at posedge.
   task automatic step(input logic cv, input logic [31:0] a, input logic [31:0] d,
                       input int sz, input logic rdy, input logic [31:0] fa);
      logic [31:0] ed;
      logic [3:0]  em;
      logic        do_enq, do_deq;
      ent_t        e;
      @(negedge clk);
      commit_valid   = cv;
      commit_addr    = a;
      commit_data    = d;
      commit_size    = mem_op_size_t'(sz);
      dmem_req_ready = rdy;
      fwd_addr       = fa;
      #1;
      check("commit_ready", 32'(commit_ready), 32'(q.size() < DEPTH));
      check("req_valid", 32'(dmem_req_valid), 32'(q.size() > 0));
      check("drain_empty", 32'(drain_empty), 32'(q.size() == 0));
      if (q.size() > 0) begin
         check("req_addr", dmem_req_addr, {q[0].waddr, 2'b00});
         check("req_wdata", dmem_req_wdata, q[0].data);
         check("req_wmask", 32'(dmem_req_wmask), 32'(q[0].mask));
      end
      model_fwd(fa, ed, em);
      check("fwd_data", fwd_data, ed);
      check("fwd_hit", 32'(fwd_hit_mask), 32'(em));
      check("fwd_valid", 32'(fwd_valid), 32'(em != 0));
      do_enq = cv && (q.size() < DEPTH) && (sz != 3);
      do_deq = rdy && (q.size() > 0);
      e      = make_ent(a, d, sz);
      @(posedge clk);
      if (do_deq) begin
         $display("drain addr=%h data=%h mask=%b", {q[0].waddr, 2'b00}, q[0].data, q[0].mask);
         void'(q.pop_front());
      end
      if (do_enq) q.push_back(e);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic        cv;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        rdy;
      logic [31:0] faddr;
      logic        ev;
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      logic [3:0]  emask;
      logic [31:0] efd;
      logic [3:0]  ehit;
   } vec_t;

   vec_t vt[16];

   initial begin
      vt[0]  = '{1, 32'h1003, 32'hAB,       0, 0, 32'h1000, 0, 0, 0, 0, 0, 0};
      vt[1]  = '{1, 32'h1002, 32'h1234,     1, 0, 32'h1000, 1, 32'h1000, 32'hABABABAB, 4'b1000, 32'hAB000000, 4'b1000};
      vt[2]  = '{1, 32'h2000, 32'hDEADBEEF, 2, 1, 32'h1000, 1, 32'h1000, 32'hABABABAB, 4'b1000, 32'h12340000, 4'b1100};
      vt[3]  = '{0, 0, 0,                   2, 1, 32'h2000, 1, 32'h1000, 32'h12341234, 4'b1100, 32'hDEADBEEF, 4'b1111};
      vt[4]  = '{0, 0, 0,                   2, 1, 32'h2000, 1, 32'h2000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 4'b1111};
      vt[5]  = '{0, 0, 0,                   2, 0, 32'h3000, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{1, 32'h3000, 32'h11223344, 2, 0, 32'h3000, 0, 0, 0, 0, 0, 0};
      vt[7]  = '{1, 32'h3001, 32'hAA,       0, 0, 32'h3000, 1, 32'h3000, 32'h11223344, 4'b1111, 32'h11223344, 4'b1111};
      vt[8]  = '{0, 0, 0,                   2, 0, 32'h3000, 1, 32'h3000, 32'h11223344, 4'b1111, 32'h1122AA44, 4'b1111};
      vt[9]  = '{0, 0, 0,                   2, 0, 32'h3004, 1, 32'h3000, 32'h11223344, 4'b1111, 32'h0, 4'b0000};
      vt[10] = '{0, 0, 0,                   2, 1, 32'h3003, 1, 32'h3000, 32'h11223344, 4'b1111, 32'h1122AA44, 4'b1111};
      vt[11] = '{0, 0, 0,                   2, 1, 32'h3000, 1, 32'h3000, 32'hAAAAAAAA, 4'b0010, 32'h0000AA00, 4'b0010};
      vt[12] = '{1, 32'h4003, 32'hBEEF,     1, 0, 32'h4000, 0, 0, 0, 0, 0, 0};
      vt[13] = '{1, 32'h5000, 32'h55,       3, 0, 32'h4000, 1, 32'h4000, 32'hBEEFBEEF, 4'b1000, 32'hBE000000, 4'b1000};
      vt[14] = '{0, 0, 0,                   2, 1, 32'h4000, 1, 32'h4000, 32'hBEEFBEEF, 4'b1000, 32'hBE000000, 4'b1000};
      vt[15] = '{0, 0, 0,                   2, 1, 32'h5000, 0, 0, 0, 0, 0, 0};
   end

   // ---------------- main sequence ----------------
   initial begin
      // Reset held with a store offered: nothing may be taken.
      commit_valid = 1'b1;
      commit_addr  = 32'h0000_0100;
      commit_data  = 32'h1234_5678;
      commit_size  = WORD;
      fwd_addr     = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("rst_commit_ready", 32'(commit_ready), 32'd1);
         check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
         check("rst_drain_empty", 32'(drain_empty), 32'd1);
         check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
         $display("reset cycle %0d", i);
      end
      commit_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         commit_valid   = vt[i].cv;
         commit_addr    = vt[i].addr;
         commit_data    = vt[i].data;
         commit_size    = mem_op_size_t'(vt[i].size);
         dmem_req_ready = vt[i].rdy;
         fwd_addr       = vt[i].faddr;
         #1;
         check("vec_commit_ready", 32'(commit_ready), 32'd1);
         check("vec_req_valid", 32'(dmem_req_valid), 32'(vt[i].ev));
         check("vec_drain_empty", 32'(drain_empty), 32'(!vt[i].ev));
         if (vt[i].ev) begin
            check("vec_req_addr", dmem_req_addr, vt[i].eaddr);
            check("vec_req_wdata", dmem_req_wdata, vt[i].ewdata);
            check("vec_req_wmask", 32'(dmem_req_wmask), 32'(vt[i].emask));
         end
         check("vec_fwd_data", fwd_data, vt[i].efd);
         check("vec_fwd_hit", 32'(fwd_hit_mask), 32'(vt[i].ehit));
         check("vec_fwd_valid", 32'(fwd_valid), 32'(vt[i].ehit != 0));
         $display("vector %0d cv=%0d addr=%h req=%0d/%h/%h/%b fwd=%h/%b", i, vt[i].cv, vt[i].addr,
                  dmem_req_valid, dmem_req_addr, dmem_req_wdata, dmem_req_wmask, fwd_data, fwd_hit_mask);
      end

      // Fill to full with the port stalled, offer a 9th, then drain in order.
      for (int i = 0; i < 9; i++)
         step(1'b1, 32'h0000_6000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2, 1'b0, 32'h0000_6000);
      check("full_count", 32'(q.size()), 32'd8);
      for (int i = 0; i < 9; i++)
         step(1'b0, 0, 0, 2, 1'b1, 32'h0000_6004);

      // Full with ready and commit together: dequeue only, then enqueue refills.
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'h0000_7000 + 32'(4 * i), 32'hD000_0000 + 32'(i), 2, 1'b0, 32'h0000_7000);
      step(1'b1, 32'h0000_7100, 32'hEEEE_0001, 2, 1'b1, 32'h0000_7100);
      step(1'b1, 32'h0000_7100, 32'hEEEE_0002, 2, 1'b0, 32'h0000_7100);
      step(1'b0, 0, 0, 2, 1'b0, 32'h0000_7100);
      check("refill_ready", 32'(commit_ready), 32'd0);
      for (int i = 0; i < 9; i++)
         step(1'b0, 0, 0, 2, 1'b1, 32'h0000_7000);

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 5; i++)
         step(1'b1, 32'h0000_8000 + 32'(4 * i), 32'hF000_0000 + 32'(i), 2, 1'b0, 32'h0000_8000);
      @(negedge clk);
      commit_valid   = 1'b0;
      dmem_req_ready = 1'b1;
      fwd_addr       = 32'h0000_8000;
      #1;
      check("mid_req_valid_before", 32'(dmem_req_valid), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_req_valid", 32'(dmem_req_valid), 32'd0);
      check("mid_rst_drain_empty", 32'(drain_empty), 32'd1);
      check("mid_rst_commit_ready", 32'(commit_ready), 32'd1);
      check("mid_rst_fwd_valid", 32'(fwd_valid), 32'd0);
      $display("async reset mid-drain");
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 32'h0000_9000, 32'h0BAD_F00D, 2, 1'b0, 32'h0000_9000);
      step(1'b0, 0, 0, 2, 1'b1, 32'h0000_9000);
      step(1'b0, 0, 0, 2, 1'b0, 32'h0000_9000);

      // Random traffic in a small address window so forwarding overlaps often.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rd, rf;
         ra = 32'h0000_0100 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         rd = $urandom;
         rf = 32'h0000_0100 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
         step(($urandom_range(0, 9) < 6), ra, rd, int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 4), rf);
      end
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 0, 0, 2, 1'b1, 32'h0000_0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
